matrix_timer: RTL and testbench

//  Skewed (diagonal) feeder for the TTPU systolic array. Converts an NxN matrix into a time-staggered

---
 rtl/ttpu_pkg.sv | 14 +
 rtl/matrix_timer_lane.sv | 35 +++
 rtl/matrix_timer.sv | 79 +++++++
 tb/tb_matrix_timer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ttpu_pkg.sv
// Shared TTPU types and sizing for the skewed matrix feeder.
package ttpu_pkg;
   localparam int unsigned N  = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned TW = $clog2(2*N-1);

   typedef logic [DW-1:0] elem_t;
   typedef elem_t vec_t [0:N-1];
   typedef elem_t mat_t [0:N-1][0:N-1];
   typedef logic [TW-1:0] step_t;

   // Final step of a pass; the counter wraps to zero after it.
   localparam step_t LAST_STEP = step_t'(2*N-2);
endpackage

// File: rtl/matrix_timer_lane.sv
// One output lane of the skewed feeder: lane LANE emits row LANE, column
// (step - LANE) when that column exists, otherwise zero.
module matrix_timer_lane
   import ttpu_pkg::*;
#(
   parameter int unsigned LANE = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  elem_t row_i [0:N-1],
   input  step_t step_i,
   output elem_t lane_o
);

   elem_t lane_q;
   elem_t lane_d;

   // Column select: match step against LANE+j for every column j; no match means out of band.
   always_comb begin
      lane_d = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (step_i == step_t'(LANE + j)) lane_d = row_i[j];
      end
   end

   // Output register: cleared on reset, held while paused.
   always_ff @(posedge clk) begin
      if (rst)     lane_q <= '0;
      else if (en) lane_q <= lane_d;
   end

   assign lane_o = lane_q;

endmodule

// File: rtl/matrix_timer.sv
// Skewed (diagonal) feeder: turns an NxN matrix into 2N-1 staggered N-lane slices.
// Optional build macro MATRIX_TIMER_CAPTURE_EN latches the matrix at step 0 so the
// source may change mid-pass; without it the matrix is read live every step.
module matrix_timer
   import ttpu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  elem_t matrix_in  [0:N-1][0:N-1],
   output elem_t vector_out [0:N-1],
   output logic  valid,
   output logic  done
);

   step_t step_q;
   step_t step_d;
   logic  valid_q;
   logic  done_q;
   mat_t  m_src;

   // Next step with wrap after the final step.
   always_comb begin
      step_d = (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
   end

   // Step counter plus registered valid/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= en;
         done_q  <= en && (step_q == LAST_STEP);
         if (en) step_q <= step_d;
      end
   end

`ifdef MATRIX_TIMER_CAPTURE_EN
   mat_t bank_q;

   // Capture bank: latch the whole matrix at each enabled step-0 edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
               bank_q[i][j] <= '0;
      end else if (en && (step_q == '0)) begin
         bank_q <= matrix_in;
      end
   end

   // Step 0 reads the live input, since the bank loads on that same edge.
   always_comb begin
      m_src = (step_q == '0) ? matrix_in : bank_q;
   end
`else
   // Live source: the matrix must be held stable for a whole pass.
   always_comb begin
      m_src = matrix_in;
   end
`endif

   for (genvar i = 0; i < N; i++) begin : g_lane
      matrix_timer_lane #(.LANE(i)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .row_i  (m_src[i]),
         .step_i (step_q),
         .lane_o (vector_out[i])
      );
   end

   assign valid = valid_q;
   assign done  = done_q;

endmodule

// File: tb/tb_matrix_timer.sv
// Directed self-checking bench for matrix_timer.
module tb_matrix_timer;
   import ttpu_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  en;
   mat_t  cur_m;
   vec_t  vout;
   logic  valid;
   logic  done;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned t_mdl  = 0;
   mat_t        bank_m;
   vec_t        last_v;

   localparam int unsigned LASTT = 2*N-2;

   matrix_timer dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .matrix_in  (cur_m),
      .vector_out (vout),
      .valid      (valid),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One enabled edge, checked against the skew rule applied to the bench's matrix.
   task automatic en_step();
      mat_t        use_m;
      int unsigned t;
      elem_t       e;
      t = t_mdl;
      if (t == 0) bank_m = cur_m;
`ifdef MATRIX_TIMER_CAPTURE_EN
      if (t == 0) use_m = cur_m;
      else        use_m = bank_m;
`else
      use_m = cur_m;
`endif
      en = 1'b1;
      tick();
      for (int i = 0; i < int'(N); i++) begin
         e = '0;
         if (t >= i && (t - i) < N) e = use_m[i][t-i];
         last_v[i] = e;
         chk($sformatf("t%0d_lane%0d", t, i), vout[i], e);
      end
      chk($sformatf("t%0d_valid", t), valid, 1'b1);
      chk($sformatf("t%0d_done", t), done, (t == LASTT));
      t_mdl = (t == LASTT) ? 0 : t + 1;
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < int'(N); i++)
         chk($sformatf("%s_lane%0d", tag, i), vout[i], 16'd0);
      chk({tag, "_valid"}, valid, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++)
         for (int j = 0; j < int'(N); j++)
            cur_m[i][j] = elem_t'(i*32 + j + 1);
      rst = 1'b1;
      en  = 1'b0;
      tick();
      tick();
      chk_zero("reset");

      rst = 1'b0;
      en_step();
      chk("e1_lane0", vout[0], 16'd1);
      chk("e1_lane1", vout[1], 16'd0);
      chk("e1_lane15", vout[15], 16'd0);
      en_step();
      chk("e2_lane0", vout[0], 16'd2);
      chk("e2_lane1", vout[1], 16'd33);
      repeat (14) en_step();
      chk("e16_lane0", vout[0], 16'd16);
      chk("e16_lane15", vout[15], 16'd481);
      repeat (15) en_step();
      chk("e31_lane15", vout[15], 16'd496);
      chk("e31_lane14", vout[14], 16'd0);
      chk("e31_done", done, 1'b1);
      en_step();
      chk("e32_lane0", vout[0], 16'd1);
      chk("e32_done", done, 1'b0);

      // Pause with step 5 pending: t=4 slice must hold.
      repeat (4) en_step();
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_lane0", vout[0], 16'd5);
         chk("hold_lane4", vout[4], 16'd129);
         for (int i = 0; i < int'(N); i++)
            chk($sformatf("hold_lane%0d", i), vout[i], last_v[i]);
         chk("hold_valid", valid, 1'b0);
         chk("hold_done", done, 1'b0);
      end
      en_step();
      chk("resume_lane0", vout[0], 16'd6);
      chk("resume_lane5", vout[5], 16'd161);

      // Reset mid-pass at t=10 with en high.
      repeat (4) en_step();
      rst = 1'b1;
      en  = 1'b1;
      tick();
      chk_zero("midrst");
      rst   = 1'b0;
      t_mdl = 0;
      en_step();
      chk("restart_lane0", vout[0], 16'd1);

      // Source change at t=3.
      repeat (2) en_step();
      for (int i = 0; i < int'(N); i++)
         for (int j = 0; j < int'(N); j++)
            cur_m[i][j] = 16'hFFFF;
      en_step();
`ifdef MATRIX_TIMER_CAPTURE_EN
      chk("chg_lane0", vout[0], 16'd4);
      chk("chg_lane3", vout[3], 16'd97);
`else
      chk("chg_lane0", vout[0], 16'hFFFF);
      chk("chg_lane3", vout[3], 16'hFFFF);
`endif
      repeat (27) en_step();
      chk("chg_end_done", done, 1'b1);
      en_step();
      chk("next_lane0", vout[0], 16'hFFFF);
      en_step();
      chk("next_lane1", vout[1], 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
